// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: opcode/func
// fields, ALU operation codes, datapath mux encodings and FSM states.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_JR  = 6'b001000;

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Register-file write address select
  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  // Register-file write data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // ALU B-input select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_REGA   = 2'b11;

  // Controller states; explicit values keep the legacy state encoding.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  // Dispatch target out of DECODE; anything unrecognised traps.
  function automatic state_t decode_next(input logic [5:0] opc, input logic [5:0] func);
    state_t nxt;
    case (opc)
      OP_R: begin
        case (func)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: nxt = S_R_EXEC;
          F_JR:                             nxt = S_JR;
          default:                          nxt = S_TRAP;
        endcase
      end
      OP_LW, OP_SW:     nxt = S_MEM_ADDR;
      OP_ADDI, OP_SLTI: nxt = S_I_EXEC;
      OP_BEQ:           nxt = S_BRANCH;
      OP_J:             nxt = S_JUMP;
      OP_JAL:           nxt = S_JAL;
      default:          nxt = S_TRAP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// R-type func field to ALU operation. Unknown funcs default to add;
// the controller never executes them because DECODE traps first.
module alu_op_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int FUNC_W = 6
) (
  input  logic [FUNC_W-1:0] func,
  output logic [2:0]        alu_op
);

  // Pure lookup of the ALU operation for an R-type func
  always_comb begin
    alu_op = ALU_ADD;
    case (func)
      F_ADD:   alu_op = ALU_ADD;
      F_SUB:   alu_op = ALU_SUB;
      F_AND:   alu_op = ALU_AND;
      F_OR:    alu_op = ALU_OR;
      F_SLT:   alu_op = ALU_SLT;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath with a single shared
// instruction/data memory port. Outputs are a Moore decode of the state,
// with a few strobes qualified by mem_ready.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OPC_W  = 6,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opc,
  input  logic [FUNC_W-1:0] func,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              i_or_d,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic [1:0]        reg_dst,
  output logic [1:0]        mem_to_reg,
  output logic              reg_write,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [2:0]        alu_op,
  output logic [1:0]        pc_src,
  output logic              instr_done,
  output logic              illegal
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] r_alu_op;

  alu_op_decoder #(
    .FUNC_W (FUNC_W)
  ) u_alu_op_decoder (
    .func   (func),
    .alu_op (r_alu_op)
  );

  // State register, asynchronously forced to FETCH while reset is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  // Next-state sequencing; memory states hold until mem_ready
  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
      S_DECODE:   state_nxt = decode_next(opc, func);
      S_MEM_ADDR: state_nxt = (opc == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_R_EXEC:   state_nxt = S_R_WB;
      S_I_EXEC:   state_nxt = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB,
      S_BRANCH, S_JUMP, S_JAL, S_JR:
                  state_nxt = S_FETCH;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_FETCH;
    endcase
  end

  // Datapath strobes; gated by rst so that a reset mid-access drops
  // every request immediately instead of exposing FETCH strobes.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = RD_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_AND;
    pc_src        = PCS_ALU;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          i_or_d    = 1'b0;
          mem_read  = 1'b1;
          alu_src_a = 1'b0;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          pc_src    = PCS_ALU;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 1'b0;
          alu_src_b = SRCB_IMMSH;
          alu_op    = ALU_ADD;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_ADD;
        end
        S_MEM_RD: begin
          i_or_d   = 1'b1;
          mem_read = 1'b1;
        end
        S_MEM_WB: begin
          reg_dst    = RD_RT;
          mem_to_reg = M2R_MDR;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          i_or_d     = 1'b1;
          mem_write  = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_REG;
          alu_op    = r_alu_op;
        end
        S_R_WB: begin
          reg_dst    = RD_RD;
          mem_to_reg = M2R_ALUOUT;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        end
        S_I_WB: begin
          reg_dst    = RD_RT;
          mem_to_reg = M2R_ALUOUT;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_REG;
          alu_op        = ALU_SUB;
          pc_src        = PCS_ALUOUT;
          pc_write_cond = 1'b1;
          instr_done    = 1'b1;
        end
        S_JUMP: begin
          pc_src     = PCS_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        // r31 takes the pre-edge PC (already PC+4) on the same edge as the jump
        S_JAL: begin
          reg_dst    = RD_R31;
          mem_to_reg = M2R_PC;
          reg_write  = 1'b1;
          pc_src     = PCS_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_JR: begin
          pc_src     = PCS_REGA;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: begin
          illegal = 1'b0;
        end
      endcase
    end
  end

  // zero is consumed by the datapath's PC-load qualifier, not here
  logic unused_zero;
  assign unused_zero = zero;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle strobe vectors from the instruction's rules,
// with random mem_ready wait cycles, and compared every cycle.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic       reg_write, alu_src_a, instr_done, illegal;
  logic [2:0] alu_op;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          zero_mode = -1;

  always #5 clk = ~clk;

  multicycle_controller #(
    .OPC_W  (6),
    .FUNC_W (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .opc           (opc),
    .func          (func),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .instr_done    (instr_done),
    .illegal       (illegal)
  );

  logic [20:0] outv;
  assign outv = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_src, instr_done, illegal};

  function automatic logic [20:0] ov(input logic pcw, pcc, iod, mr, mw, irw,
                                     input logic [1:0] rd, m2r, input logic rw, asa,
                                     input logic [1:0] asb, input logic [2:0] aop,
                                     input logic [1:0] ps, input logic dn, il);
    return {pcw, pcc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ps, dn, il};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Instruction kinds: 0 add,1 sub,2 and,3 or,4 slt,5 jr,6 lw,7 sw,8 beq,9 j,10 jal,11 addi,12 slti
  function automatic logic [11:0] kind_enc(input int k);
    case (k)
      0:  return {6'b000000, 6'b100000};
      1:  return {6'b000000, 6'b100010};
      2:  return {6'b000000, 6'b100100};
      3:  return {6'b000000, 6'b100101};
      4:  return {6'b000000, 6'b101010};
      5:  return {6'b000000, 6'b001000};
      6:  return {6'b100011, 6'($urandom)};
      7:  return {6'b101011, 6'($urandom)};
      8:  return {6'b000100, 6'($urandom)};
      9:  return {6'b000010, 6'($urandom)};
      10: return {6'b000011, 6'($urandom)};
      11: return {6'b001000, 6'($urandom)};
      default: return {6'b001010, 6'($urandom)};
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input int k);
    case (k)
      0: return 3'b010;
      1: return 3'b110;
      2: return 3'b000;
      3: return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  logic [20:0] V_F0, V_F1, V_DEC, V_MADDR, V_MRD, V_MWB, V_MWR0, V_MWR1;
  logic [20:0] V_RWB, V_IWB, V_BR, V_J, V_JAL, V_JR, V_TRAP;

  // One clock cycle: drive inputs after the edge, check mid-cycle.
  // rdy: 0/1 fixed, 2 = don't care (randomised)
  task automatic cyc(input int rdy, input logic [20:0] e, input string tag);
    @(posedge clk);
    #1;
    mem_ready = (rdy == 2) ? 1'($urandom_range(0, 1)) : (rdy == 1);
    zero      = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : (zero_mode == 1);
    #2;
    check(tag, 32'(outv), 32'(e));
  endtask

  task automatic run_instr(input int k, input int fw, input int mw);
    logic [11:0] enc;
    enc  = kind_enc(k);
    opc  = enc[11:6];
    func = enc[5:0];
    for (int i = 0; i < fw; i++) cyc(0, V_F0, "fetch_wait");
    cyc(1, V_F1, "fetch");
    cyc(2, V_DEC, "decode");
    case (k)
      0, 1, 2, 3, 4: begin
        cyc(2, ov(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,r_alu(k),2'b00,0,0), "r_exec");
        cyc(2, V_RWB, "r_wb");
      end
      5: cyc(2, V_JR, "jr");
      6: begin
        cyc(2, V_MADDR, "lw_addr");
        for (int i = 0; i < mw; i++) cyc(0, V_MRD, "mem_rd_wait");
        cyc(1, V_MRD, "mem_rd");
        cyc(2, V_MWB, "mem_wb");
      end
      7: begin
        cyc(2, V_MADDR, "sw_addr");
        for (int i = 0; i < mw; i++) cyc(0, V_MWR0, "mem_wr_wait");
        cyc(1, V_MWR1, "mem_wr");
      end
      8:  cyc(2, V_BR, "beq");
      9:  cyc(2, V_J, "j");
      10: cyc(2, V_JAL, "jal");
      default: begin
        cyc(2, ov(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,(k == 12) ? 3'b111 : 3'b010,2'b00,0,0), "i_exec");
        cyc(2, V_IWB, "i_wb");
      end
    endcase
  endtask

  // Pull reset low between edges, verify outputs drop at once, then release
  task automatic rst_pulse(input string tag);
    #1 rst = 1'b0;
    #1 check(tag, 32'(outv), 32'd0);
    @(posedge clk);
    #1 check("rst_hold", 32'(outv), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1 check("rst_release", 32'(outv), 32'(V_F0));
  endtask

  task automatic run_trap(input logic [5:0] o, input logic [5:0] f);
    opc  = o;
    func = f;
    cyc(1, V_F1, "fetch");
    cyc(2, V_DEC, "decode");
    for (int i = 0; i < 20; i++) cyc(2, V_TRAP, "trap_hold");
    rst_pulse("trap_rst");
  endtask

  initial begin
    V_F0    = ov(0,0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b010,2'b00,0,0);
    V_F1    = ov(1,0,0,1,0,1,2'b00,2'b00,0,0,2'b01,3'b010,2'b00,0,0);
    V_DEC   = ov(0,0,0,0,0,0,2'b00,2'b00,0,0,2'b11,3'b010,2'b00,0,0);
    V_MADDR = ov(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b010,2'b00,0,0);
    V_MRD   = ov(0,0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,0);
    V_MWB   = ov(0,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,3'b000,2'b00,1,0);
    V_MWR0  = ov(0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,0);
    V_MWR1  = ov(0,0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,1,0);
    V_RWB   = ov(0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,3'b000,2'b00,1,0);
    V_IWB   = ov(0,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,3'b000,2'b00,1,0);
    V_BR    = ov(0,1,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b110,2'b01,1,0);
    V_J     = ov(1,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b10,1,0);
    V_JAL   = ov(1,0,0,0,0,0,2'b10,2'b10,1,0,2'b00,3'b000,2'b10,1,0);
    V_JR    = ov(1,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b11,1,0);
    V_TRAP  = ov(0,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,1);

    // Reset with mem_ready high: even FETCH strobes must stay low
    rst = 1'b0; mem_ready = 1'b1; zero = 1'b0; opc = '0; func = '0;
    #3 check("reset_outputs", 32'(outv), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b1;
    #1 check("after_reset", 32'(outv), 32'(V_F0));

    // Directed cases
    run_instr(0, 0, 0);                 // R add, 4 cycles
    run_instr(6, 0, 3);                 // lw with 3 wait cycles, 8 cycles
    zero_mode = 1; run_instr(8, 0, 0);  // beq taken
    zero_mode = 0; run_instr(8, 0, 0);  // beq not taken
    zero_mode = -1;
    run_instr(10, 0, 0);                // jal
    run_instr(5, 1, 0);                 // jr after one fetch wait
    run_trap(6'b111111, 6'b000000);     // unknown opcode
    run_trap(6'b000000, 6'b000000);     // R-type, unknown func

    // Reset while sw is stalled in MEM_WR
    opc = 6'b101011; func = 6'b000000;
    cyc(1, V_F1, "fetch");
    cyc(2, V_DEC, "decode");
    cyc(2, V_MADDR, "sw_addr");
    cyc(0, V_MWR0, "mem_wr_wait");
    cyc(0, V_MWR0, "mem_wr_wait");
    rst_pulse("mw_rst_async");

    // Randomised instruction stream
    for (int n = 0; n < 60; n++)
      run_instr(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences a multicycle MIPS datapath, with a single shared instruction/data memory port.
- Decodes opcode/func from the instruction register and issues per-state datapath strobes.
- Stalls on a memory-ready handshake.
- Instantiated beside the multicycle datapath inside the processor top, in place of the single-cycle combinational controller.

Parameters:
- OPC_W, 6, opcode field width
- FUNC_W, 6, function field width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- opc  in  OPC_W  IR[31:26]
- func  in  FUNC_W  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load qualified by zero (datapath loads on pc_write | (pc_write_cond & zero))
- i_or_d  out  1  memory address source: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  2  write register: 00 = rt, 01 = rd, 10 = r31
- mem_to_reg  out  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B input: 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- alu_op  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = reg A
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset while rst = 0: state = FETCH, illegal = 0, every output forced to 0 (including FETCH strobes). First fetch starts in the cycle after rst rises.
- Outputs are a Moore decode of the state, except that strobes marked "on ready" below assert only while mem_ready = 1.
- Supported opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, jal = 000011, addi = 001000, slti = 001010.
- Supported R funcs: add = 100000, sub = 100010, and = 100100, or = 100101, slt = 101010, jr = 001000.
- State FETCH:
  - Drives i_or_d = 0, mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = add, pc_src = 00.
  - On ready: ir_write = 1, pc_write = 1, next state DECODE.
  - Otherwise stays in FETCH.
- State DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, alu_op = add (branch target into ALUOut).
  - Next state: lw/sw -> MEM_ADDR; R (non-jr) -> R_EXEC; R jr -> JR; addi/slti -> I_EXEC; beq -> BRANCH; j -> JUMP; jal -> JAL.
  - Any other opcode, or R-type with an unknown func -> TRAP.
- State MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = add. Next state MEM_RD for lw, MEM_WR for sw.
- State MEM_RD: i_or_d = 1, mem_read = 1. Waits for mem_ready, then goes to MEM_WB.
- State MEM_WB: reg_dst = 00, mem_to_reg = 01, reg_write = 1, instr_done = 1. Next state FETCH.
- State MEM_WR: i_or_d = 1, mem_write = 1. On ready: instr_done = 1 and next state FETCH.
- State R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op decoded from func. Next state R_WB.
- State R_WB: reg_dst = 01, mem_to_reg = 00, reg_write = 1, instr_done = 1. Next state FETCH.
- State I_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = add (addi) or slt (slti). Next state I_WB.
- State I_WB: reg_dst = 00, mem_to_reg = 00, reg_write = 1, instr_done = 1. Next state FETCH.
- State BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = sub, pc_src = 01, pc_write_cond = 1, instr_done = 1. Next state FETCH.
- State JUMP: pc_src = 10, pc_write = 1, instr_done = 1. Next state FETCH.
- State JAL: reg_dst = 10, mem_to_reg = 10, reg_write = 1, pc_src = 10, pc_write = 1, instr_done = 1. Next state FETCH.
  - The r31 write uses the PC value before the edge (already PC+4), so the register write and PC update share the same edge.
- State JR: pc_src = 11, pc_write = 1, instr_done = 1. Next state FETCH.
- State TRAP: illegal = 1, all other outputs 0. Absorbing; only reset leaves it.
- Latencies with mem_ready tied to 1:
  - R-type, addi/slti: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j, jal, jr: 3 cycles.
  - Each wait cycle on mem_ready adds exactly 1 cycle.
- mem_read and mem_write are never asserted together. Both stay held constant until mem_ready.
- mem_ready outside FETCH, MEM_RD and MEM_WR is ignored.
- Reset mid-instruction, including during a wait: outputs drop to 0 in the same cycle, without waiting for the clock. No partial write completes.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and func constants;
  - ALU operation codes;
  - mux-select encodings for reg_dst, mem_to_reg, alu_src_b and pc_src;
  - the state enumeration.
- One sub-module, alu_op_decoder: combinational, func -> 3-bit alu_op. Used in R_EXEC.

Test Plan:
- R add (opc = 000000, func = 100000), mem_ready = 1 -> states FETCH, DECODE, R_EXEC, R_WB; R_EXEC alu_op = 010; R_WB reg_dst = 01 and reg_write = 1; instr_done on cycle 4.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_read and i_or_d = 1 held for 4 cycles; MEM_WB mem_to_reg = 01; total 8 cycles.
- beq with zero = 1, then with zero = 0 -> pc_write_cond = 1 and pc_src = 01 in cycle 3 in both runs; pc_write = 0; back to FETCH.
- jal -> cycle 3 drives reg_dst = 10, mem_to_reg = 10, reg_write = 1, pc_write = 1, pc_src = 10 simultaneously.
- opc = 111111, and separately R with func = 000000 -> TRAP after DECODE; illegal = 1 held for 20 cycles; cleared only by rst = 0.
- rst driven low mid-MEM_WR while mem_ready = 0 -> mem_write falls without a clock edge; after release, FETCH with mem_read = 1 and illegal = 0.
